// File: rtl/gaussian_stream_filter.sv
// gaussian_stream_filter
//
// Streaming binomial-Gaussian filter for one raster-order grayscale frame.
// Pixels arrive on a valid/ready input stream. The filtered frame leaves in
// raster order on a valid/ready output stream. KSIZE-1 line buffers and a
// KSIZE x KSIZE window hold the neighbourhood around the output pixel.
// Border taps are zero padded. Normalisation is a round-half-up shift by
// the kernel weight sum.
//
// Parameters:
//   DATA_W - pixel width in bits
//   IMG_W  - pixels per row (>= KSIZE)
//   IMG_H  - rows per frame (>= KSIZE)
//   KSIZE  - kernel size, 3 or 5
//
// Ports:
//   clk     - sole clock, rising edge
//   rst_n   - asynchronous active-low reset
//   s_valid - input pixel valid
//   s_ready - block accepts the input pixel this cycle
//   s_data  - input pixel, unsigned
//   m_valid - output pixel valid
//   m_ready - downstream accepts the output pixel
//   m_data  - filtered pixel
//   m_last  - marks the final pixel (IMG_H-1, IMG_W-1) of a frame

module gaussian_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 220,
    parameter int IMG_H  = 168,
    parameter int KSIZE  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int D     = KSIZE / 2;
    localparam int S     = 2 * (KSIZE - 1);
    localparam int N     = IMG_W * IMG_H;
    localparam int L     = D * IMG_W + D;
    localparam int ACC_W = DATA_W + S;
    localparam int COL_W = DATA_W + S / 2;
    localparam int CNT_W = $clog2(N + 1);
    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int RND_I = 1 << (S - 1);

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("gaussian_stream_filter: KSIZE must be 3 or 5");
    end
    if (IMG_W < KSIZE || IMG_H < KSIZE) begin : g_bad_geometry
        $error("gaussian_stream_filter: IMG_W and IMG_H must be at least KSIZE");
    end

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One row of the separable binomial kernel.
    function automatic int coef(input int i);
        int c;
        if (KSIZE == 3) begin
            c = (i == 1) ? 2 : 1;
        end else begin
            case (i)
                1, 3:    c = 4;
                2:       c = 6;
                default: c = 1;
            endcase
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [X_W-1:0]     ptr_q, ptr_d;
    logic [X_W-1:0]     ox_q, ox_d;
    logic [Y_W-1:0]     oy_q, oy_d;
    logic               m_valid_q, m_valid_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               m_last_q, m_last_d;

    logic               out_ok;
    logic               adv;
    logic               produce;
    logic               is_last_px;

    logic [DATA_W-1:0]  line_mem_q [KSIZE-1][IMG_W];
    logic [DATA_W-1:0]  win_q      [KSIZE][KSIZE];
    logic [DATA_W-1:0]  win_sh     [KSIZE][KSIZE];
    logic [DATA_W-1:0]  tap        [KSIZE];

    logic               row_ok [KSIZE];
    logic               col_ok [KSIZE];
    logic [COL_W-1:0]   col_sum [KSIZE];
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     rounded;
    logic [DATA_W-1:0]  filt;

    // Handshake. A pixel position advances whenever the output register can
    // take a new value. Outside FLUSH it also needs a real input pixel.
    always_comb begin
        out_ok  = !m_valid_q || m_ready;
        s_ready = (state_q != FLUSH) && out_ok;
        adv     = out_ok && ((state_q == FLUSH) || s_valid);
        produce = adv && (state_q != FILL);
    end

    // Tap 0 is the incoming pixel. In FLUSH it is a virtual zero. Tap i is
    // the pixel exactly i rows earlier. Each line buffer is a circular row
    // read before it is overwritten at the shared column pointer.
    always_comb begin
        tap[0] = (state_q == FLUSH) ? '0 : s_data;
        for (int i = 1; i < KSIZE; i++) begin
            tap[i] = line_mem_q[i-1][ptr_q];
        end
    end

    // Window contents after this advance. Row KSIZE-1 is the newest row and
    // column KSIZE-1 the newest column, so the centre tap is output n-L.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                win_sh[r][c] = win_q[r][c+1];
            end
            win_sh[r][KSIZE-1] = tap[KSIZE-1-r];
        end
    end

    // Border masks from the coordinates of the output being produced. A
    // masked column also covers window columns that wrapped across a row
    // boundary. A masked row covers stale line-buffer rows from an earlier
    // frame.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            row_ok[r] = (int'(oy_q) + r - D >= 0) && (int'(oy_q) + r - D < IMG_H);
            col_ok[r] = (int'(ox_q) + r - D >= 0) && (int'(ox_q) + r - D < IMG_W);
        end
    end

    // Separable weighted sum: vertical sums per window column first, then
    // the horizontal pass. The divisor stays 2^S even at the border.
    always_comb begin
        acc = '0;
        for (int c = 0; c < KSIZE; c++) begin
            col_sum[c] = '0;
            for (int r = 0; r < KSIZE; r++) begin
                if (row_ok[r]) begin
                    col_sum[c] = col_sum[c] + COL_W'(win_sh[r][c]) * COL_W'(coef(r));
                end
            end
            if (col_ok[c]) begin
                acc = acc + ACC_W'(col_sum[c]) * ACC_W'(coef(c));
            end
        end
        rounded = {1'b0, acc} + (ACC_W+1)'(RND_I);
        filt    = DATA_W'(rounded >> S);
    end

    // Frame sequencing and the output register. FILL primes the window.
    // RUN pairs each input with one output. FLUSH pushes zeros to drain the
    // last L outputs.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        ptr_d      = ptr_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        is_last_px = (oy_q == Y_W'(IMG_H - 1)) && (ox_q == X_W'(IMG_W - 1));

        if (adv) begin
            ptr_d = (ptr_q == X_W'(IMG_W - 1)) ? '0 : ptr_q + X_W'(1);
            case (state_q)
                FILL: begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == CNT_W'(L - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == CNT_W'(N - 1)) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (is_last_px) begin
                        state_d  = FILL;
                        in_cnt_d = '0;
                        ptr_d    = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end

        if (produce) begin
            m_valid_d = 1'b1;
            m_data_d  = filt;
            m_last_d  = is_last_px;
            if (ox_q == X_W'(IMG_W - 1)) begin
                ox_d = '0;
                oy_d = is_last_px ? '0 : oy_q + Y_W'(1);
            end else begin
                ox_d = ox_q + X_W'(1);
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Control and output state. Reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            ptr_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            ptr_q     <= ptr_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // Pixel storage has no reset. Anything stale is masked by the border
    // logic before it can reach an output.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < KSIZE - 1; i++) begin
                line_mem_q[i][ptr_q] <= tap[i];
            end
            win_q <= win_sh;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_gaussian_stream_filter.sv
// tb_gaussian_stream_filter
//
// Bench for gaussian_stream_filter on an 8x6 frame. There is one instance
// with a 3x3 kernel and one with a 5x5 kernel. A single set of driver
// variables feeds whichever instance is selected by use5. The idle instance
// sees s_valid=0 and m_ready=1. Expected pixels come from hand-computed
// constants and from a direct 2D zero-padded convolution model.

module tb_gaussian_stream_filter;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int NPIX  = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       use5;
    logic       drv_s_valid;
    logic       drv_m_ready;
    logic [7:0] drv_s_data;

    logic       s_valid3, s_ready3, m_valid3, m_ready3, m_last3;
    logic [7:0] m_data3;
    logic       s_valid5, s_ready5, m_valid5, m_ready5, m_last5;
    logic [7:0] m_data5;

    logic       obs_s_ready, obs_m_valid, obs_m_last;
    logic [7:0] obs_m_data;

    logic [7:0] img      [0:NPIX-1];
    logic [7:0] got_data [0:NPIX-1];
    logic       got_last [0:NPIX-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Route the shared driver to the selected instance. The other one idles.
    assign s_valid3    = !use5 && drv_s_valid;
    assign m_ready3    = use5 || drv_m_ready;
    assign s_valid5    = use5 && drv_s_valid;
    assign m_ready5    = !use5 || drv_m_ready;
    assign obs_s_ready = use5 ? s_ready5 : s_ready3;
    assign obs_m_valid = use5 ? m_valid5 : m_valid3;
    assign obs_m_data  = use5 ? m_data5  : m_data3;
    assign obs_m_last  = use5 ? m_last5  : m_last3;

    gaussian_stream_filter #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid3),
        .s_ready (s_ready3),
        .s_data  (drv_s_data),
        .m_valid (m_valid3),
        .m_ready (m_ready3),
        .m_data  (m_data3),
        .m_last  (m_last3)
    );

    gaussian_stream_filter #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(5)) dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid5),
        .s_ready (s_ready5),
        .s_data  (drv_s_data),
        .m_valid (m_valid5),
        .m_ready (m_ready5),
        .m_data  (m_data5),
        .m_last  (m_last5)
    );

    function automatic int bcoef(input int k, input int i);
        int c;
        if (k == 3) begin
            c = (i == 1) ? 2 : 1;
        end else begin
            c = (i == 2) ? 6 : ((i == 1 || i == 3) ? 4 : 1);
        end
        return c;
    endfunction

    // Direct zero-padded 2D convolution of img, rounded half up.
    function automatic int model_px(input int k, input int y, input int x);
        int acc, d, s, yy, xx;
        d   = k / 2;
        s   = 2 * (k - 1);
        acc = 0;
        for (int a = 0; a < k; a++) begin
            for (int b = 0; b < k; b++) begin
                yy = y + a - d;
                xx = x + b - d;
                if (yy >= 0 && yy < IMG_H && xx >= 0 && xx < IMG_W) begin
                    acc += bcoef(k, a) * bcoef(k, b) * int'(img[yy*IMG_W + xx]);
                end
            end
        end
        return (acc + (1 << (s - 1))) >> s;
    endfunction

    // Stream img into the selected instance and collect a frame of outputs.
    // Everything is driven on the falling edge and sampled 1ns later.
    // stall_at >= 0 inserts a 10-cycle m_ready=0 window once that many
    // outputs have been taken and an output is pending.
    task automatic run_frame(input int vprob, input int rprob, input int stall_at,
                             output int n_out, output int flush_low, output int first_acc);
        int         n_in;
        bit         stalled;
        logic [7:0] held;
        n_in      = 0;
        n_out     = 0;
        flush_low = 0;
        first_acc = -1;
        stalled   = 1'b0;
        for (int cyc = 0; cyc < 4000 && n_out < NPIX; cyc++) begin
            @(negedge clk);
            if (stall_at >= 0 && !stalled && n_out >= stall_at && obs_m_valid === 1'b1) begin
                stalled = 1'b1;
                held    = obs_m_data;
                for (int s = 0; s < 10; s++) begin
                    drv_m_ready = 1'b0;
                    drv_s_valid = (n_in < NPIX);
                    drv_s_data  = (n_in < NPIX) ? img[n_in] : 8'h00;
                    #1;
                    checks++;
                    if (obs_m_valid !== 1'b1 || obs_m_data !== held) begin
                        failures++;
                        $display("[TB] FAIL stall_hold cycle=%0d got valid=%b data=%0d exp valid=1 data=%0d",
                                 s, obs_m_valid, obs_m_data, held);
                    end
                    checks++;
                    if (obs_s_ready !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL stall_s_ready cycle=%0d got=%b exp=0", s, obs_s_ready);
                    end
                    @(negedge clk);
                end
            end
            drv_s_valid = (n_in < NPIX) && (int'($urandom_range(99)) < vprob);
            drv_s_data  = (drv_s_valid && n_in < NPIX) ? img[n_in] : 8'h00;
            drv_m_ready = (int'($urandom_range(99)) < rprob);
            #1;
            if (first_acc < 0 && obs_m_valid === 1'b1) first_acc = n_in;
            if (n_in == NPIX && obs_s_ready === 1'b0) flush_low++;
            if (drv_m_ready && obs_m_valid === 1'b1) begin
                got_data[n_out] = obs_m_data;
                got_last[n_out] = obs_m_last;
                n_out++;
            end
            if (drv_s_valid && obs_s_ready === 1'b1) n_in++;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        use5        = 1'b0;
        drv_s_valid = 1'b0;
        drv_s_data  = 8'h00;
        drv_m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (m_valid3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid3 got=%b exp=0", m_valid3); end
        checks++;
        if (m_data3 !== 8'd0) begin failures++; $display("[TB] FAIL reset_m_data3 got=%0d exp=0", m_data3); end
        checks++;
        if (m_last3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_last3 got=%b exp=0", m_last3); end
        checks++;
        if (m_valid5 !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid5 got=%b exp=0", m_valid5); end
        checks++;
        if (m_data5 !== 8'd0) begin failures++; $display("[TB] FAIL reset_m_data5 got=%0d exp=0", m_data5); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (s_ready3 !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready3 got=%b exp=1", s_ready3); end
        checks++;
        if (s_ready5 !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready5 got=%b exp=1", s_ready5); end
    endtask

    task automatic test_constant_k3;
        int n_out, flush_low, first_acc, exp_v;
        use5 = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
        run_frame(100, 100, -1, n_out, flush_low, first_acc);
        checks++;
        if (n_out != NPIX) begin failures++; $display("[TB] FAIL const3_count got=%0d exp=%0d", n_out, NPIX); end
        checks++;
        if (flush_low != 9) begin failures++; $display("[TB] FAIL const3_flush_s_ready_low got=%0d exp=9", flush_low); end
        checks++;
        if (got_data[0] !== 8'd56) begin failures++; $display("[TB] FAIL const3_corner got=%0d exp=56", got_data[0]); end
        checks++;
        if (got_data[3] !== 8'd75) begin failures++; $display("[TB] FAIL const3_top_edge got=%0d exp=75", got_data[3]); end
        checks++;
        if (got_data[2*IMG_W+3] !== 8'd100) begin failures++; $display("[TB] FAIL const3_interior got=%0d exp=100", got_data[2*IMG_W+3]); end
        for (int i = 0; i < n_out; i++) begin
            exp_v = model_px(3, i / IMG_W, i % IMG_W);
            checks++;
            if (int'(got_data[i]) != exp_v) begin
                failures++;
                $display("[TB] FAIL const3_px idx=%0d got=%0d exp=%0d", i, got_data[i], exp_v);
            end
            checks++;
            if (got_last[i] !== (i == NPIX - 1)) begin
                failures++;
                $display("[TB] FAIL const3_last idx=%0d got=%b exp=%b", i, got_last[i], (i == NPIX - 1));
            end
        end
    endtask

    task automatic test_impulse_k3;
        int n_out, flush_low, first_acc, dy, dx, w, exp_v;
        use5 = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
        img[2*IMG_W+3] = 8'd255;
        run_frame(100, 100, -1, n_out, flush_low, first_acc);
        checks++;
        if (n_out != NPIX) begin failures++; $display("[TB] FAIL impulse_count got=%0d exp=%0d", n_out, NPIX); end
        for (int i = 0; i < n_out; i++) begin
            dy = i / IMG_W - 2;
            dx = i % IMG_W - 3;
            if (dy >= -1 && dy <= 1 && dx >= -1 && dx <= 1) begin
                w     = ((dy == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1);
                exp_v = (w == 4) ? 64 : ((w == 2) ? 32 : 16);
            end else begin
                exp_v = 0;
            end
            checks++;
            if (int'(got_data[i]) != exp_v) begin
                failures++;
                $display("[TB] FAIL impulse_px y=%0d x=%0d got=%0d exp=%0d", i / IMG_W, i % IMG_W, got_data[i], exp_v);
            end
        end
    endtask

    task automatic test_latency_k3;
        int n_out, flush_low, first_acc;
        use5 = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i * 5);
        run_frame(100, 100, -1, n_out, flush_low, first_acc);
        checks++;
        if (first_acc != 10) begin failures++; $display("[TB] FAIL latency_first_valid got_accepted=%0d exp=10", first_acc); end
        checks++;
        if (n_out != NPIX) begin failures++; $display("[TB] FAIL latency_count got=%0d exp=%0d", n_out, NPIX); end
        checks++;
        if (int'(got_data[NPIX-1]) != model_px(3, IMG_H - 1, IMG_W - 1)) begin
            failures++;
            $display("[TB] FAIL latency_last_px got=%0d exp=%0d", got_data[NPIX-1], model_px(3, IMG_H - 1, IMG_W - 1));
        end
    endtask

    task automatic test_constant_k5;
        int n_out, flush_low, first_acc, exp_v;
        use5 = 1'b1;
        for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
        run_frame(100, 100, -1, n_out, flush_low, first_acc);
        checks++;
        if (n_out != NPIX) begin failures++; $display("[TB] FAIL const5_count got=%0d exp=%0d", n_out, NPIX); end
        checks++;
        if (got_data[0] !== 8'd121) begin failures++; $display("[TB] FAIL const5_corner got=%0d exp=121", got_data[0]); end
        checks++;
        if (got_data[2] !== 8'd175) begin failures++; $display("[TB] FAIL const5_top_edge got=%0d exp=175", got_data[2]); end
        checks++;
        if (got_data[2*IMG_W+2] !== 8'd255) begin failures++; $display("[TB] FAIL const5_interior got=%0d exp=255", got_data[2*IMG_W+2]); end
        for (int i = 0; i < n_out; i++) begin
            exp_v = model_px(5, i / IMG_W, i % IMG_W);
            checks++;
            if (int'(got_data[i]) != exp_v) begin
                failures++;
                $display("[TB] FAIL const5_px idx=%0d got=%0d exp=%0d", i, got_data[i], exp_v);
            end
        end
    endtask

    task automatic test_back_to_back_k5;
        int n_out, flush_low, first_acc, exp_v;
        use5 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
            run_frame(70, 70, (f == 1) ? 20 : -1, n_out, flush_low, first_acc);
            checks++;
            if (n_out != NPIX) begin failures++; $display("[TB] FAIL b2b_count frame=%0d got=%0d exp=%0d", f, n_out, NPIX); end
            for (int i = 0; i < n_out; i++) begin
                exp_v = model_px(5, i / IMG_W, i % IMG_W);
                checks++;
                if (int'(got_data[i]) != exp_v) begin
                    failures++;
                    $display("[TB] FAIL b2b_px frame=%0d idx=%0d got=%0d exp=%0d", f, i, got_data[i], exp_v);
                end
                checks++;
                if (got_last[i] !== (i == NPIX - 1)) begin
                    failures++;
                    $display("[TB] FAIL b2b_last frame=%0d idx=%0d got=%b exp=%b", f, i, got_last[i], (i == NPIX - 1));
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        int n_out, flush_low, first_acc, exp_v;
        use5 = 1'b1;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drv_s_valid = 1'b1;
            drv_s_data  = img[i];
            drv_m_ready = 1'b1;
        end
        @(negedge clk);
        drv_s_valid = 1'b0;
        #1;
        checks++;
        if (obs_m_valid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre_valid got=%b exp=1", obs_m_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_m_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_async_drop got=%b exp=0", obs_m_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
        run_frame(80, 80, -1, n_out, flush_low, first_acc);
        checks++;
        if (n_out != NPIX) begin failures++; $display("[TB] FAIL midreset_count got=%0d exp=%0d", n_out, NPIX); end
        for (int i = 0; i < n_out; i++) begin
            exp_v = model_px(5, i / IMG_W, i % IMG_W);
            checks++;
            if (int'(got_data[i]) != exp_v) begin
                failures++;
                $display("[TB] FAIL midreset_px idx=%0d got=%0d exp=%0d", i, got_data[i], exp_v);
            end
        end
    endtask

    // Last-resort guard in case a wait goes wrong outside the bounded loops.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_constant_k3();
        test_impulse_k3();
        test_latency_k3();
        test_constant_k5();
        test_back_to_back_k5();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
